// File: rtl/mem_arbiter.sv
// Shared memory-port arbiter for icache and dcache. Dcache has priority; a starvation
// counter force-grants icache, and an owner table routes returning data tags.
package mem_arbiter_pkg;
  typedef enum logic [1:0] {
    MEM_NONE  = 2'h0,
    MEM_LOAD  = 2'h1,
    MEM_STORE = 2'h2
  } MEM_COMMAND;
endpackage

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  MEM_COMMAND  Icache2mem_command,
  input  logic [31:0] Icache2mem_addr,
  input  MEM_COMMAND  Dcache2mem_command,
  input  logic [31:0] Dcache2mem_addr,
  input  logic [63:0] Dcache2mem_data,
  input  logic [3:0]  mem2proc_transaction_tag,
  input  logic [63:0] mem2proc_data,
  input  logic [3:0]  mem2proc_data_tag,
  output MEM_COMMAND  proc2mem_command,
  output logic [31:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  output logic [3:0]  Imem2proc_transaction_tag,
  output logic [3:0]  Imem2proc_data_tag,
  output logic [63:0] Imem2proc_data,
  output logic [3:0]  Dmem2proc_transaction_tag,
  output logic [3:0]  Dmem2proc_data_tag,
  output logic [63:0] Dmem2proc_data,
  output logic        dcache_request
);

  logic [3:0]  r_starve_cnt;
  logic [15:0] r_valid;
  logic [15:0] r_owner;

  logic w_i_req;
  logic w_d_req;
  logic w_starve;
  logic w_grant_d;
  logic w_accept;
  logic w_ret_hit;

  assign w_i_req   = (Icache2mem_command != MEM_NONE);
  assign w_d_req   = (Dcache2mem_command != MEM_NONE);
  assign w_starve  = w_i_req && ({28'd0, r_starve_cnt} >= 32'(STARVE_LIMIT));
  // Grant depends only on requests and registered state, never on the response tags.
  assign w_grant_d = w_d_req && !w_starve;

  assign dcache_request   = w_grant_d;
  assign proc2mem_command = w_grant_d ? Dcache2mem_command : Icache2mem_command;
  assign proc2mem_addr    = w_grant_d ? Dcache2mem_addr :
                            (w_i_req ? Icache2mem_addr : 32'h0);
  assign proc2mem_data    = w_grant_d ? Dcache2mem_data : 64'h0;

  assign Dmem2proc_transaction_tag = w_grant_d ? mem2proc_transaction_tag : 4'h0;
  assign Imem2proc_transaction_tag = w_grant_d ? 4'h0 : mem2proc_transaction_tag;

  assign w_accept  = (proc2mem_command == MEM_LOAD) && (mem2proc_transaction_tag != 4'h0);
  assign w_ret_hit = (mem2proc_data_tag != 4'h0) && r_valid[mem2proc_data_tag];

  assign Imem2proc_data_tag = (w_ret_hit && !r_owner[mem2proc_data_tag]) ?
                              mem2proc_data_tag : 4'h0;
  assign Dmem2proc_data_tag = (w_ret_hit && r_owner[mem2proc_data_tag]) ?
                              mem2proc_data_tag : 4'h0;
  assign Imem2proc_data     = mem2proc_data;
  assign Dmem2proc_data     = mem2proc_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid      <= 16'h0;
      r_owner      <= 16'h0;
      r_starve_cnt <= 4'h0;
    end else begin
      // Retire first so a same-tag allocation in this cycle takes precedence.
      if (w_ret_hit) r_valid[mem2proc_data_tag] <= 1'b0;
      if (w_accept) begin
        r_valid[mem2proc_transaction_tag] <= 1'b1;
        r_owner[mem2proc_transaction_tag] <= w_grant_d;
      end
      if (w_i_req && w_grant_d) begin
        if (r_starve_cnt != 4'hF) r_starve_cnt <= r_starve_cnt + 4'h1;
      end else if (w_i_req && (mem2proc_transaction_tag != 4'h0)) begin
        r_starve_cnt <= 4'h0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table/counter model checked every cycle on the
// falling edge, plus hand-computed expectations for each scenario.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int LIMIT = 8;

  logic        clock = 1'b0;
  logic        reset;
  MEM_COMMAND  icmd, dcmd;
  logic [31:0] iaddr, daddr;
  logic [63:0] ddata, mdata;
  logic [3:0]  ttag, dtag;
  MEM_COMMAND  p_cmd;
  logic [31:0] p_addr;
  logic [63:0] p_data, i_data, d_data;
  logic [3:0]  i_tt, i_dt, d_tt, d_dt;
  logic        dreq;

  int checks = 0;
  int failures = 0;

  // model state
  bit m_valid[16];
  bit m_owner[16];
  int m_starve = 0;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .Icache2mem_command(icmd), .Icache2mem_addr(iaddr),
    .Dcache2mem_command(dcmd), .Dcache2mem_addr(daddr), .Dcache2mem_data(ddata),
    .mem2proc_transaction_tag(ttag), .mem2proc_data(mdata), .mem2proc_data_tag(dtag),
    .proc2mem_command(p_cmd), .proc2mem_addr(p_addr), .proc2mem_data(p_data),
    .Imem2proc_transaction_tag(i_tt), .Imem2proc_data_tag(i_dt), .Imem2proc_data(i_data),
    .Dmem2proc_transaction_tag(d_tt), .Dmem2proc_data_tag(d_dt), .Dmem2proc_data(d_data),
    .dcache_request(dreq)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_owner[i] = 1'b0;
    end
    m_starve = 0;
  endtask

  always @(posedge reset) model_clear();

  // Per-cycle compare, then advance the model to the state after the coming edge.
  always @(negedge clock) begin
    bit ir, dr, gd, rt;
    MEM_COMMAND e_cmd;
    logic [31:0] e_addr;
    ir = (icmd != MEM_NONE);
    dr = (dcmd != MEM_NONE);
    gd = dr && !(ir && m_starve >= LIMIT);
    e_cmd  = gd ? dcmd : (ir ? icmd : MEM_NONE);
    e_addr = gd ? daddr : (ir ? iaddr : 32'h0);
    rt = (dtag != 0) && m_valid[dtag];
    chk("m_dreq", dreq, gd);
    chk("m_cmd", p_cmd, e_cmd);
    chk("m_addr", p_addr, e_addr);
    chk("m_data", p_data, gd ? ddata : 64'h0);
    chk("m_i_tt", i_tt, gd ? 4'h0 : ttag);
    chk("m_d_tt", d_tt, gd ? ttag : 4'h0);
    chk("m_i_dt", i_dt, (rt && !m_owner[dtag]) ? dtag : 4'h0);
    chk("m_d_dt", d_dt, (rt && m_owner[dtag]) ? dtag : 4'h0);
    chk("m_i_data", i_data, mdata);
    chk("m_d_data", d_data, mdata);
    if (reset) begin
      model_clear();
    end else begin
      if (rt) m_valid[dtag] = 1'b0;
      if (e_cmd == MEM_LOAD && ttag != 0) begin
        m_valid[ttag] = 1'b1;
        m_owner[ttag] = gd;
      end
      if (ir && gd) m_starve = (m_starve < 15) ? m_starve + 1 : 15;
      else if (ir && ttag != 0) m_starve = 0;
    end
  end

  // Drive one cycle of inputs just after the rising edge; return just after the falling edge.
  task automatic cyc(input MEM_COMMAND ic, input logic [31:0] ia,
                     input MEM_COMMAND dc, input logic [31:0] da, input logic [63:0] dd,
                     input logic [3:0] tt, input logic [3:0] dt, input logic [63:0] md);
    @(posedge clock);
    #1;
    icmd = ic; iaddr = ia; dcmd = dc; daddr = da; ddata = dd;
    ttag = tt; dtag = dt; mdata = md;
    @(negedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    icmd = MEM_NONE; dcmd = MEM_NONE;
    iaddr = 0; daddr = 0; ddata = 0; ttag = 0; dtag = 0; mdata = 0;
    model_clear();

    // In reset: grant follows requests, no routed data tags.
    cyc(MEM_NONE, 32'h0, MEM_LOAD, 32'h40, 64'h0, 4'd0, 4'd1, 64'h0);
    chk("rst_dreq", dreq, 1'b1);
    chk("rst_d_dt", d_dt, 4'h0);
    cyc(MEM_NONE, 32'hFFFF, MEM_NONE, 32'h0, 64'h0, 4'd0, 4'd0, 64'h0);
    chk("idle_addr", p_addr, 32'h0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Icache load, tag 3, later returned and then retired.
    cyc(MEM_LOAD, 32'h100, MEM_NONE, 32'h0, 64'h0, 4'd3, 4'd0, 64'h0);
    chk("ld_addr", p_addr, 32'h100);
    chk("ld_i_tt", i_tt, 4'd3);
    chk("ld_d_tt", d_tt, 4'd0);
    chk("ld_dreq", dreq, 1'b0);
    cyc(MEM_NONE, 32'h0, MEM_NONE, 32'h0, 64'h0, 4'd0, 4'd0, 64'h0);
    cyc(MEM_NONE, 32'h0, MEM_NONE, 32'h0, 64'h0, 4'd0, 4'd3, 64'hDEAD_BEEF);
    chk("ret_i_dt", i_dt, 4'd3);
    chk("ret_i_data", i_data, 64'hDEAD_BEEF);
    chk("ret_d_dt", d_dt, 4'd0);
    cyc(MEM_NONE, 32'h0, MEM_NONE, 32'h0, 64'h0, 4'd0, 4'd3, 64'h1);
    chk("retired_i_dt", i_dt, 4'd0);

    // Dcache store, tag 7: no allocation.
    cyc(MEM_NONE, 32'h0, MEM_STORE, 32'h200, 64'h55, 4'd7, 4'd0, 64'h0);
    chk("st_data", p_data, 64'h55);
    chk("st_d_tt", d_tt, 4'd7);
    cyc(MEM_NONE, 32'h0, MEM_NONE, 32'h0, 64'h0, 4'd0, 4'd7, 64'h2);
    chk("st_i_dt", i_dt, 4'd0);
    chk("st_d_dt", d_dt, 4'd0);

    // Starvation: dcache wins 8 cycles, icache forced on the 9th, then dcache again.
    for (int k = 1; k <= 10; k++) begin
      cyc(MEM_LOAD, 32'h300, MEM_LOAD, 32'h400, 64'h0, 4'd5, 4'd0, 64'h0);
      chk("starve_dreq", dreq, (k == 9) ? 1'b0 : 1'b1);
      if (k == 9) chk("starve_addr", p_addr, 32'h300);
    end
    cyc(MEM_NONE, 32'h0, MEM_NONE, 32'h0, 64'h0, 4'd0, 4'd5, 64'h3);
    chk("t5_d_dt", d_dt, 4'd5);

    // Same-cycle return of icache tag 4 and dcache re-allocation of tag 4.
    cyc(MEM_LOAD, 32'h500, MEM_NONE, 32'h0, 64'h0, 4'd4, 4'd0, 64'h0);
    cyc(MEM_NONE, 32'h0, MEM_LOAD, 32'h600, 64'h0, 4'd4, 4'd4, 64'h4);
    chk("same_i_dt", i_dt, 4'd4);
    chk("same_d_dt", d_dt, 4'd0);
    chk("same_dreq", dreq, 1'b1);
    cyc(MEM_NONE, 32'h0, MEM_NONE, 32'h0, 64'h0, 4'd0, 4'd4, 64'h5);
    chk("realloc_d_dt", d_dt, 4'd4);
    chk("realloc_i_dt", i_dt, 4'd0);

    // Mid-cycle async reset with tags 2 (icache) and 9 (dcache) outstanding.
    cyc(MEM_LOAD, 32'h700, MEM_NONE, 32'h0, 64'h0, 4'd2, 4'd0, 64'h0);
    cyc(MEM_NONE, 32'h0, MEM_LOAD, 32'h800, 64'h0, 4'd9, 4'd0, 64'h0);
    cyc(MEM_NONE, 32'h0, MEM_NONE, 32'h0, 64'h0, 4'd0, 4'd0, 64'h0);
    chk("pre_rst_valid", dut.r_valid, 16'h0204);
    @(posedge clock);
    #2 reset = 1'b1;
    #1 chk("rst_valid", dut.r_valid, 16'h0000);
    #1 reset = 1'b0;
    cyc(MEM_NONE, 32'h0, MEM_NONE, 32'h0, 64'h0, 4'd0, 4'd2, 64'h6);
    chk("drop2_i_dt", i_dt, 4'd0);
    chk("drop2_d_dt", d_dt, 4'd0);
    cyc(MEM_NONE, 32'h0, MEM_NONE, 32'h0, 64'h0, 4'd0, 4'd9, 64'h7);
    chk("drop9_d_dt", d_dt, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
